// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - ALU flag register and ARM-style condition evaluation behind a valid/ready handshake
module cond_flag_unit #(
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_we,
  input  logic             n_in,
  input  logic             z_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             req_valid,
  input  logic [3:0]       req_cond,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_pass,
  input  logic             resp_ready,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_q, state_d;
  logic       accept, fire;
  logic [3:0] eval_flags;
  logic       fn, fz, fc, fv;
  logic       eval_pass;

  assign resp_valid = (state_q == FULL);
  assign req_ready  = ~resp_valid | resp_ready;
  assign accept     = req_valid & req_ready;
  assign fire       = resp_valid & resp_ready;

  // Same-cycle flag writes are only visible to the evaluation when bypass is built in
  assign eval_flags = (BYPASS && flag_we) ? {n_in, z_in, c_in, v_in} : flags_q;

  always_comb begin
    {fn, fz, fc, fv} = eval_flags;
    eval_pass = 1'b0;
    case (req_cond)
      4'd0:    eval_pass = fz;
      4'd1:    eval_pass = ~fz;
      4'd2:    eval_pass = fc;
      4'd3:    eval_pass = ~fc;
      4'd4:    eval_pass = fn;
      4'd5:    eval_pass = ~fn;
      4'd6:    eval_pass = fv;
      4'd7:    eval_pass = ~fv;
      4'd8:    eval_pass = fc & ~fz;
      4'd9:    eval_pass = ~fc | fz;
      4'd10:   eval_pass = (fn == fv);
      4'd11:   eval_pass = (fn != fv);
      4'd12:   eval_pass = ~fz & (fn == fv);
      4'd13:   eval_pass = fz | (fn != fv);
      4'd14:   eval_pass = 1'b1;
      default: eval_pass = 1'b0;
    endcase
  end

  // In FULL an accept implies resp_ready, so the old response always leaves as the new one lands
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (fire && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      flags_q   <= 4'b0000;
      resp_pass <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (flag_we)
        flags_q <= {n_in, z_in, c_in, v_in};
      if (accept)
        resp_pass <= eval_pass;
      if (fire) begin
        if (resp_pass) begin
          if (pass_cnt != '1)
            pass_cnt <= pass_cnt + CNT_ONE;
        end else if (fail_cnt != '1) begin
          fail_cnt <= fail_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - scoreboard bench for cond_flag_unit (no-bypass/16-bit and bypass/2-bit instances)
module tb_cond_flag_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flag_we, n_in, z_in, c_in, v_in, req_valid, resp_ready;
  logic [3:0]  req_cond;
  logic        rdy0, rdy1, vld0, vld1, ps0, ps1;
  logic [3:0]  fq0, fq1;
  logic [15:0] pc0, fc0;
  logic [1:0]  pc1, fc1;

  cond_flag_unit #(.BYPASS(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flag_we(flag_we), .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .req_valid(req_valid), .req_cond(req_cond), .req_ready(rdy0), .resp_valid(vld0),
    .resp_pass(ps0), .resp_ready(resp_ready), .flags_q(fq0), .pass_cnt(pc0), .fail_cnt(fc0));

  cond_flag_unit #(.BYPASS(1'b1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .flag_we(flag_we), .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .req_valid(req_valid), .req_cond(req_cond), .req_ready(rdy1), .resp_valid(vld1),
    .resp_pass(ps1), .resp_ready(resp_ready), .flags_q(fq1), .pass_cnt(pc1), .fail_cnt(fc1));

  logic        vld [2];
  logic        ps  [2];
  logic [15:0] pcw [2];
  logic [15:0] fcw [2];
  assign vld[0] = vld0;  assign vld[1] = vld1;
  assign ps[0]  = ps0;   assign ps[1]  = ps1;
  assign pcw[0] = pc0;   assign pcw[1] = {14'd0, pc1};
  assign fcw[0] = fc0;   assign fcw[1] = {14'd0, fc1};

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q [$];
  bit         acc_now = 1'b0;
  logic [3:0] mflags = 4'b0000;
  int         exp_pc [2] = '{0, 0};
  int         exp_fc [2] = '{0, 0};
  int         lim    [2] = '{65535, 3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pairs of codes share a predicate; the odd code of each pair is its negation
  function automatic bit cond_true(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond >> 1)
      0:       base = z;
      1:       base = c;
      2:       base = n;
      3:       base = v;
      4:       base = c && !z;
      5:       base = (n == v);
      6:       base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  task automatic step();
    bit         pend, acc;
    logic [3:0] fin;
    fin  = {n_in, z_in, c_in, v_in};
    pend = (exp_q.size() != 0);
    chk("flags_q0", fq0, mflags);
    chk("flags_q1", fq1, mflags);
    chk("req_ready0", rdy0, !pend || resp_ready);
    chk("req_ready1", rdy1, !pend || resp_ready);
    acc = req_valid && (!pend || resp_ready);
    if (acc)
      exp_q.push_back({cond_true(req_cond, flag_we ? fin : mflags), cond_true(req_cond, mflags)});
    if (flag_we)
      mflags = fin;
    acc_now = acc;
  endtask

  task automatic cycle(input bit fwe, input logic [3:0] f, input bit rv, input logic [3:0] cond, input bit rr);
    @(posedge clk); #1;
    flag_we = fwe; {n_in, z_in, c_in, v_in} = f;
    req_valid = rv; req_cond = cond; resp_ready = rr;
    @(negedge clk);
    step();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    flag_we = 1'($urandom); {n_in, z_in, c_in, v_in} = 4'($urandom);
    req_valid = 1'($urandom); req_cond = 4'($urandom); resp_ready = 1'($urandom);
    @(negedge clk);
    chk("rst flags_q0", fq0, 0);       chk("rst flags_q1", fq1, 0);
    chk("rst resp_valid0", vld0, 0);   chk("rst resp_valid1", vld1, 0);
    chk("rst resp_pass0", ps0, 0);     chk("rst resp_pass1", ps1, 0);
    chk("rst pass_cnt0", pc0, 0);      chk("rst fail_cnt0", fc0, 0);
    chk("rst pass_cnt1", pc1, 0);      chk("rst fail_cnt1", fc1, 0);
    chk("rst req_ready0", rdy0, 1);    chk("rst req_ready1", rdy1, 1);
    exp_q.delete();
    mflags = 4'b0000;
    exp_pc = '{0, 0};
    exp_fc = '{0, 0};
    acc_now = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; flag_we = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    step();
  endtask

  // Monitor: checks the presented response and counters, retires the response when it fires
  initial begin
    bit pend;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        pend = (exp_q.size() > int'(acc_now));
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("resp_valid%0d", d), vld[d], pend);
          if (pend)
            chk($sformatf("resp_pass%0d", d), ps[d], exp_q[0][d]);
          chk($sformatf("pass_cnt%0d", d), pcw[d], exp_pc[d]);
          chk($sformatf("fail_cnt%0d", d), fcw[d], exp_fc[d]);
        end
        if (pend && resp_ready) begin
          for (int d = 0; d < 2; d++) begin
            if (exp_q[0][d]) begin
              if (exp_pc[d] < lim[d]) exp_pc[d]++;
            end else if (exp_fc[d] < lim[d]) begin
              exp_fc[d]++;
            end
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flag_we = 1'b0; {n_in, z_in, c_in, v_in} = 4'b0000;
    req_valid = 1'b0; req_cond = 4'd0; resp_ready = 1'b1;
    do_reset();

    // EQ / NE on Z=1
    cycle(1, 4'b0100, 0, 4'd0, 1);
    cycle(0, 4'b0000, 1, 4'd0, 1);
    cycle(0, 4'b0000, 1, 4'd1, 1);
    // signed compares on N=V=1, then Z=1
    cycle(1, 4'b1001, 0, 4'd0, 1);
    for (int i = 10; i < 14; i++) cycle(0, 4'b0000, 1, 4'(i), 1);
    cycle(1, 4'b0100, 0, 4'd0, 1);
    cycle(0, 4'b0000, 1, 4'd12, 1);
    cycle(0, 4'b0000, 1, 4'd13, 1);
    // backpressure with flag writes while the response is held
    cycle(0, 4'b0000, 1, 4'd0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 4'($urandom), 1, 4'($urandom), 0);
    cycle(0, 4'b0000, 0, 4'd0, 1);
    // same-cycle flag write and request
    cycle(1, 4'b0000, 0, 4'd0, 1);
    cycle(1, 4'b0100, 1, 4'd0, 1);
    cycle(0, 4'b0000, 0, 4'd0, 1);
    // saturation of the narrow counters, then reset with a response pending
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 4'b0000, 1, 4'd14, 1);
    cycle(0, 4'b0000, 0, 4'd0, 1);
    cycle(0, 4'b0000, 1, 4'd15, 0);
    cycle(0, 4'b0000, 0, 4'd0, 0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        do_reset();
      else
        cycle($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 2) != 0,
              4'($urandom), $urandom_range(0, 3) != 0);
    end
    cycle(0, 4'b0000, 0, 4'd0, 1);
    cycle(0, 4'b0000, 0, 4'd0, 1);
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
